// File: rtl/xeng_corr_apply.sv
// xeng_corr_apply
//   Removes the unsigned-offset DC terms from raw X-engine baseline
//   accumulations: dout = xeng - (correction << OFFSET_SHIFT), exact and
//   computed in OUT_WIDTH bits. The data path is a fixed 2-cycle pipeline.
//   The block also tags each output with its baseline index within the
//   integration frame. It checks that the tracker's buffer select and
//   last-triangle flags stay aligned with the data stream.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   sync                frame start, aligned with baseline 0 (or idle)
//   din_vld             qualifies xeng_*, *_correction, last_triangle, buf_sel
//   xeng_re/xeng_im     signed raw accumulations (ACC_WIDTH)
//   re/im_correction    signed DC correction terms (CORR_WIDTH)
//   last_triangle       tracker last-triangle flag
//   buf_sel             tracker buffer select, toggles once per frame
//   dout_vld            output valid, 2 cycles after din_vld
//   dout_re/dout_im     signed corrected results (OUT_WIDTH)
//   dout_bl_idx         baseline index within frame
//   dout_last           final baseline of a frame (index N_BL-1)
//   dout_last_triangle  last_triangle travelling with the data
//   err_align           sticky alignment error, cleared only by reset
module xeng_corr_apply #(
  parameter int N_ANTS       = 32,
  parameter int CORR_WIDTH   = 16,
  parameter int ACC_WIDTH    = 24,
  parameter int OFFSET_SHIFT = 3,
  parameter int OUT_WIDTH    = ACC_WIDTH + 1,
  localparam int N_TAPS      = N_ANTS / 2 + 1,
  localparam int N_BL        = N_ANTS * N_TAPS,
  localparam int BL_W        = $clog2(N_BL),
  localparam int TAP_W       = $clog2(N_TAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sync,
  input  logic                         din_vld,
  input  logic signed [ACC_WIDTH-1:0]  xeng_re,
  input  logic signed [ACC_WIDTH-1:0]  xeng_im,
  input  logic signed [CORR_WIDTH-1:0] re_correction,
  input  logic signed [CORR_WIDTH-1:0] im_correction,
  input  logic                         last_triangle,
  input  logic                         buf_sel,
  output logic                         dout_vld,
  output logic signed [OUT_WIDTH-1:0]  dout_re,
  output logic signed [OUT_WIDTH-1:0]  dout_im,
  output logic [BL_W-1:0]              dout_bl_idx,
  output logic                         dout_last,
  output logic                         dout_last_triangle,
  output logic                         err_align
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // ---------------- input-side arithmetic ----------------
  logic signed [OUT_WIDTH-1:0] w_re_ext, w_im_ext, w_re_corr, w_im_corr;

  assign w_re_ext  = OUT_WIDTH'(xeng_re);
  assign w_im_ext  = OUT_WIDTH'(xeng_im);
  assign w_re_corr = OUT_WIDTH'(re_correction) <<< OFFSET_SHIFT;
  assign w_im_corr = OUT_WIDTH'(im_correction) <<< OFFSET_SHIFT;

  // ---------------- baseline / tap-group counters ----------------
  // The tap counter runs alongside bl_cnt so that N_TAPS group boundaries
  // are known without a modulo on the index.
  logic [BL_W-1:0]  r_bl_cnt, w_bl_nxt, w_in_idx;
  logic [TAP_W-1:0] r_tap_cnt, w_tap_nxt;
  logic             w_in_last, w_in_grp0;

  always_comb begin
    w_bl_nxt  = r_bl_cnt;
    w_tap_nxt = r_tap_cnt;
    w_in_idx  = r_bl_cnt;
    w_in_grp0 = (r_tap_cnt == '0);
    w_in_last = 1'b0;
    if (sync) begin
      // sync wins over a coincident wrap
      w_in_idx  = '0;
      w_in_grp0 = 1'b1;
      w_bl_nxt  = din_vld ? BL_W'(1)  : '0;
      w_tap_nxt = din_vld ? TAP_W'(1) : '0;
    end else if (din_vld) begin
      w_in_last = (r_bl_cnt == BL_W'(N_BL - 1));
      if (w_in_last) begin
        w_bl_nxt  = '0;
        w_tap_nxt = '0;
      end else begin
        w_bl_nxt  = r_bl_cnt + BL_W'(1);
        w_tap_nxt = (r_tap_cnt == TAP_W'(N_TAPS - 1)) ? '0 : r_tap_cnt + TAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bl_cnt  <= '0;
      r_tap_cnt <= '0;
    end else begin
      r_bl_cnt  <= w_bl_nxt;
      r_tap_cnt <= w_tap_nxt;
    end
  end

  // ---------------- stage 1 ----------------
  logic signed [OUT_WIDTH-1:0] r_s1_re_ext, r_s1_im_ext, r_s1_re_corr, r_s1_im_corr;
  logic [BL_W-1:0]             r_s1_idx;
  logic                        r_s1_vld, r_s1_sync, r_s1_last, r_s1_lt, r_s1_bsel, r_s1_grp0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_re_ext  <= '0;
      r_s1_im_ext  <= '0;
      r_s1_re_corr <= '0;
      r_s1_im_corr <= '0;
      r_s1_idx     <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_sync    <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_lt      <= 1'b0;
      r_s1_bsel    <= 1'b0;
      r_s1_grp0    <= 1'b0;
    end else begin
      r_s1_re_ext  <= w_re_ext;
      r_s1_im_ext  <= w_im_ext;
      r_s1_re_corr <= w_re_corr;
      r_s1_im_corr <= w_im_corr;
      r_s1_idx     <= w_in_idx;
      r_s1_vld     <= din_vld;
      r_s1_sync    <= sync;
      r_s1_last    <= din_vld & w_in_last;
      r_s1_lt      <= din_vld & last_triangle;
      r_s1_bsel    <= din_vld & buf_sel;
      r_s1_grp0    <= w_in_grp0;
    end
  end

  // ---------------- stage 2 (outputs) ----------------
  logic signed [OUT_WIDTH-1:0] r_dout_re, r_dout_im;
  logic [BL_W-1:0]             r_dout_idx;
  logic                        r_dout_vld, r_dout_last, r_dout_lt;
  logic                        r_s2_sync, r_s2_bsel, r_s2_grp0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_re   <= '0;
      r_dout_im   <= '0;
      r_dout_idx  <= '0;
      r_dout_vld  <= 1'b0;
      r_dout_last <= 1'b0;
      r_dout_lt   <= 1'b0;
      r_s2_sync   <= 1'b0;
      r_s2_bsel   <= 1'b0;
      r_s2_grp0   <= 1'b0;
    end else begin
      r_dout_re   <= r_s1_re_ext - r_s1_re_corr;
      r_dout_im   <= r_s1_im_ext - r_s1_im_corr;
      r_dout_idx  <= r_s1_idx;
      r_dout_vld  <= r_s1_vld;
      r_dout_last <= r_s1_last;
      r_dout_lt   <= r_s1_lt;
      r_s2_sync   <= r_s1_sync;
      r_s2_bsel   <= r_s1_bsel;
      r_s2_grp0   <= r_s1_grp0;
    end
  end

  // ---------------- frame FSM and alignment checks ----------------
  // Checks run on the output stage, so err_align rises one cycle after the
  // offending sample appears on dout. r_primed means buf_ref holds a value
  // taken from a valid sample of the current run.
  state_t r_state, w_state_nxt;
  logic   r_buf_ref, r_primed, r_lt_prev, r_err, w_viol;

  always_comb begin
    w_state_nxt = r_state;
    w_viol      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_s2_sync) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (r_dout_vld && !r_s2_sync && r_primed) begin
          if (r_dout_idx == '0) begin
            if (r_s2_bsel == r_buf_ref) w_viol = 1'b1;
          end else if (r_s2_bsel != r_buf_ref) begin
            w_viol = 1'b1;
          end
          if (!r_s2_grp0 && (r_dout_lt != r_lt_prev)) w_viol = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_buf_ref <= 1'b0;
      r_primed  <= 1'b0;
      r_lt_prev <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_err | w_viol;
      if (r_dout_vld) r_lt_prev <= r_dout_lt;
      if (r_s2_sync) begin
        r_primed <= r_dout_vld;
        if (r_dout_vld) r_buf_ref <= r_s2_bsel;
      end else if ((r_state == ST_RUN) && r_dout_vld) begin
        if (!r_primed) begin
          r_primed  <= 1'b1;
          r_buf_ref <= r_s2_bsel;
        end else if (r_dout_idx == '0) begin
          r_buf_ref <= r_s2_bsel;
        end
      end
    end
  end

  assign dout_vld           = r_dout_vld;
  assign dout_re            = r_dout_re;
  assign dout_im            = r_dout_im;
  assign dout_bl_idx        = r_dout_idx;
  assign dout_last          = r_dout_last;
  assign dout_last_triangle = r_dout_lt;
  assign err_align          = r_err;

endmodule
